switch_cfg_sequencer: RTL



---
 rtl/switch_cfg_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/switch_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : switch_cfg_sequencer
// Description : Upstream sequencer for the 16x16 switch configuration array.
//               Accepts load/commit commands on a valid/ready handshake and
//               drives the shared in_add bus, one-hot out_sel, load_en strobe
//               and global conf_en strobe of the downstream switch cells.
//               Every output comes straight from a flop so the strobes seen
//               by the edge-triggered cells are glitch-free.
//
// Ports       : clk, reset          - clock, synchronous active-high reset
//               cmd_valid/cmd_ready - command handshake (ready only in IDLE)
//               cmd_commit          - 0 = load, 1 = commit
//               cmd_out_port        - target port of a load
//               cmd_in_add          - input address of a load
//               in_add, out_sel     - address bus and one-hot port select
//               load_en, conf_en    - load and commit strobes
//               busy                - inverse of cmd_ready
//               load_count, pending - loads since last commit (saturating)
//               err                 - one-cycle pulse on an out-of-range port
//
// Revision    : 1.0 - initial release
// ============================================================================
module switch_cfg_sequencer #(
    parameter int N_PORTS       = 16,
    parameter int ADDR_W        = 4,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_commit,
    input  logic [ADDR_W-1:0]   cmd_out_port,
    input  logic [ADDR_W-1:0]   cmd_in_add,
    output logic [ADDR_W-1:0]   in_add,
    output logic [N_PORTS-1:0]  out_sel,
    output logic                load_en,
    output logic                conf_en,
    output logic                busy,
    output logic [ADDR_W:0]     load_count,
    output logic                pending,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_L_SETUP  = 3'd1,
        S_L_STROBE = 3'd2,
        S_L_HOLD   = 3'd3,
        S_C_STROBE = 3'd4,
        S_C_HOLD   = 3'd5
    } state_t;

    localparam logic [2:0]         c_strb_last = 3'(STROBE_CYCLES - 1);
    localparam logic [ADDR_W:0]    c_n_ports   = (ADDR_W + 1)'(N_PORTS);
    localparam logic [N_PORTS-1:0] c_sel_one   = {{(N_PORTS - 1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]    c_cnt_one   = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    logic [2:0]          r_strb_cnt;
    logic [ADDR_W-1:0]   r_in_add;
    logic [N_PORTS-1:0]  r_out_sel;
    logic                r_load_en;
    logic                r_conf_en;
    logic [ADDR_W:0]     r_load_count;
    logic                r_pending;
    logic                r_err;
    logic                r_ready;
    logic                r_busy;

    state_t              w_state_nxt;
    logic [2:0]          w_strb_cnt_nxt;
    logic [ADDR_W-1:0]   w_in_add_nxt;
    logic [N_PORTS-1:0]  w_out_sel_nxt;
    logic                w_load_en_nxt;
    logic                w_conf_en_nxt;
    logic [ADDR_W:0]     w_load_count_nxt;
    logic                w_err_nxt;
    logic                w_accept;
    logic                w_port_bad;
    logic [N_PORTS-1:0]  w_sel_dec;
    logic [ADDR_W:0]     w_count_inc;

    // r_ready is registered from the next state, so it always equals
    // (r_state == S_IDLE) without a decode on the output path.
    assign w_accept    = cmd_valid & r_ready;
    assign w_port_bad  = ({1'b0, cmd_out_port} >= c_n_ports);
    assign w_sel_dec   = c_sel_one << cmd_out_port;
    assign w_count_inc = (r_load_count == '1) ? r_load_count
                                              : r_load_count + c_cnt_one;

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed one cycle
    // ahead and registered, so each state's outputs appear in the cycle
    // the FSM occupies that state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_strb_cnt_nxt   = r_strb_cnt;
        w_in_add_nxt     = r_in_add;
        w_out_sel_nxt    = r_out_sel;
        w_load_en_nxt    = 1'b0;
        w_conf_en_nxt    = 1'b0;
        w_load_count_nxt = r_load_count;
        w_err_nxt        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_out_sel_nxt = '0;
                if (w_accept) begin
                    if (cmd_commit) begin
                        w_state_nxt    = S_C_STROBE;
                        w_conf_en_nxt  = 1'b1;
                        w_strb_cnt_nxt = 3'd0;
                    end else if (w_port_bad) begin
                        // Rejected load: flag it and stay idle, bus untouched.
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = S_L_SETUP;
                        w_in_add_nxt  = cmd_in_add;
                        w_out_sel_nxt = w_sel_dec;
                    end
                end
            end

            S_L_SETUP: begin
                w_state_nxt    = S_L_STROBE;
                w_load_en_nxt  = 1'b1;
                w_strb_cnt_nxt = 3'd0;
            end

            S_L_STROBE: begin
                if (r_strb_cnt == c_strb_last) begin
                    w_state_nxt      = S_L_HOLD;
                    w_load_count_nxt = w_count_inc;
                end else begin
                    w_strb_cnt_nxt = r_strb_cnt + 3'd1;
                    w_load_en_nxt  = 1'b1;
                end
            end

            S_L_HOLD: begin
                // Bus was held through this cycle; release select on exit.
                w_state_nxt   = S_IDLE;
                w_out_sel_nxt = '0;
            end

            S_C_STROBE: begin
                if (r_strb_cnt == c_strb_last) begin
                    w_state_nxt      = S_C_HOLD;
                    w_load_count_nxt = '0;
                end else begin
                    w_strb_cnt_nxt = r_strb_cnt + 3'd1;
                    w_conf_en_nxt  = 1'b1;
                end
            end

            S_C_HOLD: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_out_sel_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_strb_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_strb_cnt <= w_strb_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output registers. Reset truncates any strobe in flight; the cells
    // share the same reset so no half-written state survives.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_add     <= '0;
            r_out_sel    <= '0;
            r_load_en    <= 1'b0;
            r_conf_en    <= 1'b0;
            r_load_count <= '0;
            r_pending    <= 1'b0;
            r_err        <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_in_add     <= w_in_add_nxt;
            r_out_sel    <= w_out_sel_nxt;
            r_load_en    <= w_load_en_nxt;
            r_conf_en    <= w_conf_en_nxt;
            r_load_count <= w_load_count_nxt;
            r_pending    <= (w_load_count_nxt != '0);
            r_err        <= w_err_nxt;
            r_ready      <= (w_state_nxt == S_IDLE);
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign cmd_ready  = r_ready;
    assign busy       = r_busy;
    assign in_add     = r_in_add;
    assign out_sel    = r_out_sel;
    assign load_en    = r_load_en;
    assign conf_en    = r_conf_en;
    assign load_count = r_load_count;
    assign pending    = r_pending;
    assign err        = r_err;

endmodule
`default_nettype wire
